rd_ctrl_fwft: RTL and testbench

Parametrised read-side controller for the dual-clock FIFO, running entirely in the read clock domain. Owns the binary/Gray read pointer, drives the FIFO memory read address, registers the read data, and reports empty, almost-empty, occupancy level and sticky underflow. Selectable standard or first-word-fall-through (FWFT) mode. Sits between the write-pointer 2-flop synchroniser and the read-side consumer.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/gray_to_bin.sv | 15 +
 rtl/rd_ctrl_fwft.sv | 127 ++++++++++++
 tb/tb_rd_ctrl_fwft.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Helpers shared by the read- and write-side FIFO controllers: Gray coding,
// pointer width and read-mode selection.
package fifo_pkg;

  typedef enum logic {
    RD_MODE_STD  = 1'b0,
    RD_MODE_FWFT = 1'b1
  } rd_mode_e;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2(32) doubling steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of parametrised width (up to 32 bits).
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = WIDTH'(gray2bin(32'(i_gray)));
  end

endmodule

// File: rtl/rd_ctrl_fwft.sv
// Read-side controller of the dual-clock FIFO: read pointer, read address,
// registered read data and empty / almost-empty / level / underflow flags.
module rd_ctrl_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FWFT          = 0
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH:0]   rd_q2_wr_ptr,
  input  logic [ADDRESS_WIDTH:0]   rd_aempty_thresh,
  input  logic                     rd_uf_clr,
  input  logic [DATA_WIDTH-1:0]    rd_mem_data,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [ADDRESS_WIDTH:0]   rd_ptr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     fifo_empty,
  output logic                     fifo_aempty,
  output logic [ADDRESS_WIDTH:0]   rd_level,
  output logic                     rd_underflow
);

  localparam int unsigned PW   = ptr_width(ADDRESS_WIDTH);
  localparam rd_mode_e    MODE = (FWFT != 0) ? RD_MODE_FWFT : RD_MODE_STD;

  logic [PW-1:0]         r_ptr_bin;
  logic [PW-1:0]         r_ptr_gray;
  logic [PW-1:0]         r_level;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_mem_empty;
  logic                  r_valid;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_underflow;

  logic [PW-1:0] w_wr_bin;
  logic [PW-1:0] w_ptr_bin_nxt;
  logic [PW-1:0] w_ptr_gray_nxt;
  logic [PW-1:0] w_mem_level;
  logic [PW-1:0] w_level_nxt;
  logic          w_mem_empty_nxt;
  logic          w_empty_nxt;
  logic          w_fetch;
  logic          w_valid_nxt;
  logic          w_uf_set;

  gray_to_bin #(.WIDTH(PW)) u_wr_g2b (
    .i_gray (rd_q2_wr_ptr),
    .o_bin  (w_wr_bin)
  );

  // Mode-specific fetch/valid/underflow terms depend only on registers and
  // inputs, keeping the shared pointer/level logic free of feedback.
  if (MODE == RD_MODE_FWFT) begin : g_fwft
    always_comb begin
      w_fetch     = ~r_mem_empty & (~r_valid | rd_en);
      w_valid_nxt = r_valid;
      if (w_fetch) begin
        w_valid_nxt = 1'b1;
      end else if (rd_en & r_valid) begin
        w_valid_nxt = 1'b0;
      end
      w_uf_set = rd_en & ~r_valid;
    end
  end else begin : g_std
    always_comb begin
      w_fetch     = rd_en & ~r_mem_empty;
      w_valid_nxt = w_fetch;
      w_uf_set    = rd_en & r_mem_empty;
    end
  end

  always_comb begin
    w_ptr_bin_nxt   = r_ptr_bin + PW'(w_fetch);
    w_ptr_gray_nxt  = PW'(bin2gray(32'(w_ptr_bin_nxt)));
    w_mem_empty_nxt = (w_ptr_gray_nxt == rd_q2_wr_ptr);
    w_mem_level     = w_wr_bin - w_ptr_bin_nxt;
    if (MODE == RD_MODE_FWFT) begin
      // The word parked in the output stage still counts as readable.
      w_level_nxt = w_mem_level + PW'(w_valid_nxt);
      w_empty_nxt = ~w_valid_nxt;
    end else begin
      w_level_nxt = w_mem_level;
      w_empty_nxt = w_mem_empty_nxt;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_ptr_bin   <= '0;
      r_ptr_gray  <= '0;
      r_level     <= '0;
      r_data      <= '0;
      r_mem_empty <= 1'b1;
      r_valid     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_ptr_bin   <= w_ptr_bin_nxt;
      r_ptr_gray  <= w_ptr_gray_nxt;
      r_mem_empty <= w_mem_empty_nxt;
      r_valid     <= w_valid_nxt;
      if (w_fetch) begin
        r_data <= rd_mem_data;
      end
      r_empty     <= w_empty_nxt;
      r_level     <= w_level_nxt;
      r_aempty    <= (w_level_nxt <= rd_aempty_thresh);
      r_underflow <= w_uf_set | (r_underflow & ~rd_uf_clr);
    end
  end

  assign rd_addr      = r_ptr_bin[ADDRESS_WIDTH-1:0];
  assign rd_ptr       = r_ptr_gray;
  assign rd_data      = r_data;
  assign rd_valid     = r_valid;
  assign fifo_empty   = r_empty;
  assign fifo_aempty  = r_aempty;
  assign rd_level     = r_level;
  assign rd_underflow = r_underflow;

endmodule

// File: tb/tb_rd_ctrl_fwft.sv
// Randomized bench: one standard and one FWFT controller share a write-side
// stimulus and are compared against word-count models of the read side.
module tb_rd_ctrl_fwft;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] thresh;
  logic          s_en, s_clr, f_en, f_clr;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] s_addr, f_addr;
  logic [PW-1:0] s_ptr, f_ptr, s_level, f_level;
  logic [DW-1:0] s_data, f_data, s_mdata, f_mdata;
  logic          s_valid, f_valid, s_empty, f_empty;
  logic          s_aempty, f_aempty, s_uf, f_uf;

  always #5 clk = ~clk;

  assign s_mdata = mem[s_addr];
  assign f_mdata = mem[f_addr];

  rd_ctrl_fwft #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) dut_std (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(s_en), .rd_q2_wr_ptr(wr_gray),
    .rd_aempty_thresh(thresh), .rd_uf_clr(s_clr), .rd_mem_data(s_mdata),
    .rd_addr(s_addr), .rd_ptr(s_ptr), .rd_data(s_data), .rd_valid(s_valid),
    .fifo_empty(s_empty), .fifo_aempty(s_aempty), .rd_level(s_level),
    .rd_underflow(s_uf)
  );

  rd_ctrl_fwft #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) dut_fwft (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(f_en), .rd_q2_wr_ptr(wr_gray),
    .rd_aempty_thresh(thresh), .rd_uf_clr(f_clr), .rd_mem_data(f_mdata),
    .rd_addr(f_addr), .rd_ptr(f_ptr), .rd_data(f_data), .rd_valid(f_valid),
    .fifo_empty(f_empty), .fifo_aempty(f_aempty), .rd_level(f_level),
    .rd_underflow(f_uf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words[] holds every word ever written since reset, in order.
  int words [4096];
  int wr, wr_prev;
  int s_rp, m_s_valid, m_s_data, m_s_level, m_s_empty, m_s_aempty, m_s_uf;
  int f_rp, f_have, m_f_data, m_f_level, m_f_empty, m_f_aempty, m_f_uf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int gray_of(input int n);
    int b;
    b = n % 32;
    return b ^ (b >> 1);
  endfunction

  task automatic reset_model();
    wr = 0; wr_prev = 0;
    s_rp = 0; m_s_valid = 0; m_s_data = 0; m_s_level = 0;
    m_s_empty = 1; m_s_aempty = 1; m_s_uf = 0;
    f_rp = 0; f_have = 0; m_f_data = 0; m_f_level = 0;
    m_f_empty = 1; m_f_aempty = 1; m_f_uf = 0;
  endtask

  // Advance both models across one rising edge using the inputs now applied.
  task automatic model_step();
    int avail, fetch, ufset;
    avail = wr_prev - s_rp;
    fetch = (s_en && avail > 0) ? 1 : 0;
    ufset = (s_en && avail == 0) ? 1 : 0;
    if (fetch != 0) begin
      m_s_data = words[s_rp];
      s_rp++;
    end
    m_s_valid = fetch;
    m_s_uf    = (ufset != 0) ? 1 : (s_clr ? 0 : m_s_uf);

    avail = wr_prev - f_rp;
    fetch = (avail > 0 && (f_have == 0 || f_en)) ? 1 : 0;
    ufset = (f_en && f_have == 0) ? 1 : 0;
    if (fetch != 0) begin
      m_f_data = words[f_rp];
      f_rp++;
      f_have = 1;
    end else if (f_en && f_have != 0) begin
      f_have = 0;
    end
    m_f_uf = (ufset != 0) ? 1 : (f_clr ? 0 : m_f_uf);

    wr_prev    = wr;
    m_s_level  = wr - s_rp;
    m_s_empty  = (m_s_level == 0) ? 1 : 0;
    m_s_aempty = (m_s_level <= int'(thresh)) ? 1 : 0;
    m_f_level  = wr - f_rp + f_have;
    m_f_empty  = (f_have == 0) ? 1 : 0;
    m_f_aempty = (m_f_level <= int'(thresh)) ? 1 : 0;
  endtask

  task automatic check_all();
    check("std_valid",  32'(s_valid),  32'(m_s_valid));
    check("std_data",   32'(s_data),   32'(m_s_data));
    check("std_empty",  32'(s_empty),  32'(m_s_empty));
    check("std_aempty", 32'(s_aempty), 32'(m_s_aempty));
    check("std_level",  32'(s_level),  32'(m_s_level));
    check("std_uf",     32'(s_uf),     32'(m_s_uf));
    check("std_ptr",    32'(s_ptr),    32'(gray_of(s_rp)));
    check("std_addr",   32'(s_addr),   32'(s_rp % DEPTH));
    check("fwft_valid",  32'(f_valid),  32'(f_have));
    check("fwft_data",   32'(f_data),   32'(m_f_data));
    check("fwft_empty",  32'(f_empty),  32'(m_f_empty));
    check("fwft_aempty", 32'(f_aempty), 32'(m_f_aempty));
    check("fwft_level",  32'(f_level),  32'(m_f_level));
    check("fwft_uf",     32'(f_uf),     32'(m_f_uf));
    check("fwft_ptr",    32'(f_ptr),    32'(gray_of(f_rp)));
    check("fwft_addr",   32'(f_addr),   32'(f_rp % DEPTH));
  endtask

  initial begin
    rst_n = 1'b0; wr_gray = '0; thresh = 5'd2;
    s_en = 1'b0; s_clr = 1'b0; f_en = 1'b0; f_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    reset_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      int fill, v;
      @(negedge clk);
      check_all();

      if (cyc == 700) begin
        #2;
        reset_model();
        wr_gray = '0; s_en = 1'b0; f_en = 1'b0; s_clr = 1'b0; f_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        model_step();
        continue;
      end

      fill = ((cyc / 60) % 2 == 0) ? 1 : 0;
      if ($urandom_range(0, 3) < ((fill != 0) ? 3 : 1) &&
          (wr - s_rp) < DEPTH && (wr - f_rp + f_have) < DEPTH) begin
        v = int'($urandom_range(0, 255));
        mem[wr % DEPTH] = DW'(v);
        words[wr] = v;
        wr++;
        wr_gray = PW'(gray_of(wr));
      end
      s_en  = ($urandom_range(0, 11) < ((fill != 0) ? 4 : 9));
      f_en  = ($urandom_range(0, 11) < ((fill != 0) ? 4 : 9));
      s_clr = ($urandom_range(0, 7) == 0);
      f_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) thresh = PW'($urandom_range(0, 16));
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
